// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet decoder: FSM states, status-byte
// bit positions, mouse command/response codes and the decoded report payload.
package ps2_mouse_pkg;

    // Byte position within a mouse packet; S_B3 exists only with MOUSE_WHEEL_EN
    typedef enum logic [1:0] {
        S_B0 = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2,
        S_B3 = 2'd3
    } state_t;

    // Status byte (byte 0) bit positions
    localparam int unsigned BTN_L = 0;
    localparam int unsigned BTN_R = 1;
    localparam int unsigned BTN_M = 2;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned XS    = 4;
    localparam int unsigned YS    = 5;
    localparam int unsigned XO    = 6;
    localparam int unsigned YO    = 7;

    // Host commands and device responses seen during mouse init
    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;

    // Decoded packet as presented to the drawing logic
    typedef struct packed {
        logic [2:0] buttons;
        logic [8:0] dx;
        logic [8:0] dy;
        logic [3:0] wheel;
    } mouse_report_t;

    // 9-bit two's complement delta; an overflowed axis contributes nothing
    function automatic logic [8:0] axis_delta(input logic sign, input logic ovf,
                                              input logic [7:0] mag);
        return ovf ? 9'd0 : {sign, mag};
    endfunction

endpackage

// File: rtl/mouse_axis_clamp.sv
// Saturating add of a signed 9-bit mouse delta to an unsigned cursor coordinate,
// clamped to [0, MAX]. negate subtracts the delta instead (screen-down Y axis).
module mouse_axis_clamp
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned COORD_W = 8,
    parameter int unsigned MAX     = 63
) (
    input  logic [COORD_W-1:0] coord,
    input  logic [8:0]         delta,
    input  logic               negate,
    output logic [COORD_W-1:0] result_c
);

    // Two guard bits cover coordinate range plus the full +/-256 delta swing
    localparam int unsigned AW = COORD_W + 2;
    localparam logic signed [AW-1:0] MAX_S = AW'(MAX);

    logic signed [AW-1:0] base_s;
    logic signed [AW-1:0] delta_s;
    logic signed [AW-1:0] sum_s;

    // Widen, add, then saturate at both ends
    always_comb begin
        base_s  = signed'({2'b00, coord});
        delta_s = AW'($signed(delta));
        if (negate) begin
            delta_s = -delta_s;
        end
        sum_s = base_s + delta_s;
        if (sum_s[AW-1]) begin
            result_c = '0;
        end else if (sum_s > MAX_S) begin
            result_c = COORD_W'(MAX);
        end else begin
            result_c = sum_s[COORD_W-1:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_packet.sv
// PS/2 mouse packet assembler: collects 3-byte packets from the host receiver,
// decodes buttons and signed X/Y deltas and maintains a clamped cursor.
// Resynchronises on a missing sync bit, receiver error or inter-byte timeout.
// Define MOUSE_WHEEL_EN for 4-byte IntelliMouse packets with wheel delta.
module ps2_mouse_packet
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 27000000,
    parameter int unsigned TIMEOUT_US = 1500,
    parameter int unsigned COORD_W    = 8,
    parameter int unsigned X_MAX      = 63,
    parameter int unsigned Y_MAX      = 63
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               rx_err,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic [2:0]         buttons,
    output logic [8:0]         dx_out,
    output logic [8:0]         dy_out,
    output logic [3:0]         wheel,
    output logic               pkt_valid,
    output logic               sync_err
);

    localparam int unsigned TIMEOUT_CYC = CLK_FREQ / 1000000 * TIMEOUT_US;
    localparam int unsigned CNT_W       = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [7:0]         status_q, status_nxt;
    logic [7:0]         xbyte_q, xbyte_nxt;
`ifdef MOUSE_WHEEL_EN
    logic [7:0]         ybyte_q, ybyte_nxt;
`endif
    logic               apply_c;
    logic               sync_err_nxt;
    logic [7:0]         fin_y_c;
    logic [3:0]         wheel_c;
    logic [8:0]         dx_c, dy_c;
    logic [COORD_W-1:0] nx_c, ny_c;
    mouse_report_t      report_q;

    // FSM and byte-latch registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_B0;
            cnt_q    <= '0;
            status_q <= '0;
            xbyte_q  <= '0;
`ifdef MOUSE_WHEEL_EN
            ybyte_q  <= '0;
`endif
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            status_q <= status_nxt;
            xbyte_q  <= xbyte_nxt;
`ifdef MOUSE_WHEEL_EN
            ybyte_q  <= ybyte_nxt;
`endif
        end
    end

    // Next state: byte sequencing, error/timeout resync, final-byte apply
    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        status_nxt   = status_q;
        xbyte_nxt    = xbyte_q;
`ifdef MOUSE_WHEEL_EN
        ybyte_nxt    = ybyte_q;
`endif
        apply_c      = 1'b0;
        sync_err_nxt = 1'b0;

        if (!enable) begin
            state_nxt = S_B0;
            cnt_nxt   = '0;
        end else if (state_q == S_B0) begin
            cnt_nxt = '0;
            if (rx_valid) begin
                if (rx_data[SYNC]) begin
                    status_nxt = rx_data;
                    state_nxt  = S_B1;
                end else begin
                    sync_err_nxt = 1'b1;
                end
            end
        end else if (rx_err) begin
            state_nxt    = S_B0;
            cnt_nxt      = '0;
            sync_err_nxt = 1'b1;
        end else if (rx_valid) begin
            cnt_nxt = '0;
            case (state_q)
                S_B1: begin
                    xbyte_nxt = rx_data;
                    state_nxt = S_B2;
                end
                S_B2: begin
`ifdef MOUSE_WHEEL_EN
                    ybyte_nxt = rx_data;
                    state_nxt = S_B3;
`else
                    // status_q always has SYNC set here; the gate is defensive
                    apply_c   = status_q[SYNC];
                    state_nxt = S_B0;
`endif
                end
`ifdef MOUSE_WHEEL_EN
                S_B3: begin
                    apply_c   = status_q[SYNC];
                    state_nxt = S_B0;
                end
`endif
                default: state_nxt = S_B0;
            endcase
        end else if (cnt_q == TO_LAST) begin
            state_nxt    = S_B0;
            cnt_nxt      = '0;
            sync_err_nxt = 1'b1;
        end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end
    end

    // Final-byte decode: the last byte comes straight from rx_data
    always_comb begin
`ifdef MOUSE_WHEEL_EN
        fin_y_c = ybyte_q;
        wheel_c = rx_data[3:0];
`else
        fin_y_c = rx_data;
        wheel_c = 4'd0;
`endif
        dx_c = axis_delta(status_q[XS], status_q[XO], xbyte_q);
        dy_c = axis_delta(status_q[YS], status_q[YO], fin_y_c);
    end

    mouse_axis_clamp #(
        .COORD_W (COORD_W),
        .MAX     (X_MAX)
    ) u_clamp_x (
        .coord    (cursor_x),
        .delta    (dx_c),
        .negate   (1'b0),
        .result_c (nx_c)
    );

    // Mouse Y is up-positive, screen Y is down-positive
    mouse_axis_clamp #(
        .COORD_W (COORD_W),
        .MAX     (Y_MAX)
    ) u_clamp_y (
        .coord    (cursor_y),
        .delta    (dy_c),
        .negate   (1'b1),
        .result_c (ny_c)
    );

    // Output registers: update on the edge that accepts the final byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_x  <= COORD_W'(X_MAX >> 1);
            cursor_y  <= COORD_W'(Y_MAX >> 1);
            report_q  <= '0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            pkt_valid <= apply_c;
            sync_err  <= sync_err_nxt;
            if (apply_c) begin
                cursor_x         <= nx_c;
                cursor_y         <= ny_c;
                report_q.buttons <= status_q[BTN_M:BTN_L];
                report_q.dx      <= dx_c;
                report_q.dy      <= dy_c;
                report_q.wheel   <= wheel_c;
            end
        end
    end

    assign buttons = report_q.buttons;
    assign dx_out  = report_q.dx;
    assign dy_out  = report_q.dy;
    assign wheel   = report_q.wheel;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Scoreboard bench for ps2_mouse_packet (default 3-byte build).
module tb_ps2_mouse_packet;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] cursor_x, cursor_y;
    logic [2:0] buttons;
    logic [8:0] dx_out, dy_out;
    logic [3:0] wheel;
    logic       pkt_valid, sync_err;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] b;
        logic [8:0] dx;
        logic [8:0] dy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   sync_pending = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ps2_mouse_packet dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .buttons   (buttons),
        .dx_out    (dx_out),
        .dy_out    (dy_out),
        .wheel     (wheel),
        .pkt_valid (pkt_valid),
        .sync_err  (sync_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_err();
        rx_err = 1'b1;
        @(negedge clk);
        rx_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Push the expected result, then stream the three bytes back to back
    task automatic send_pkt(input logic [7:0] s, input logic [7:0] xb, input logic [7:0] yb,
                            input logic [7:0] ex, input logic [7:0] ey, input logic [2:0] eb,
                            input logic [8:0] edx, input logic [8:0] edy);
        exp_t e;
        e.x = ex; e.y = ey; e.b = eb; e.dx = edx; e.dy = edy;
        exp_q.push_back(e);
        send_byte(s);
        send_byte(xb);
        send_byte(yb);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cursor_x"}, 32'(cursor_x), 32'd31);
        check({tag, "_cursor_y"}, 32'(cursor_y), 32'd31);
        check({tag, "_buttons"},  32'(buttons),  32'd0);
        check({tag, "_dx_out"},   32'(dx_out),   32'd0);
        check({tag, "_dy_out"},   32'(dy_out),   32'd0);
        check({tag, "_wheel"},    32'(wheel),    32'd0);
        check({tag, "_pkt_valid"}, 32'(pkt_valid), 32'd0);
        check({tag, "_sync_err"},  32'(sync_err),  32'd0);
    endtask

    // Monitor: every strobe must match the head of its scoreboard queue
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pkt_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("pkt_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pkt_cursor_x", 32'(cursor_x), 32'(mon_e.x));
                    check("pkt_cursor_y", 32'(cursor_y), 32'(mon_e.y));
                    check("pkt_buttons",  32'(buttons),  32'(mon_e.b));
                    check("pkt_dx_out",   32'(dx_out),   32'(mon_e.dx));
                    check("pkt_dy_out",   32'(dy_out),   32'(mon_e.dy));
                    check("pkt_wheel",    32'(wheel),    32'd0);
                end
            end
            if (sync_err === 1'b1) begin
                if (sync_pending == 0) begin
                    check("sync_err_unexpected", 32'd1, 32'd0);
                end else begin
                    n_cmp++;
                    sync_pending--;
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        idle(3);
        check_reset_values("reset");
        rst_n = 1'b1;
        idle(1);
        enable = 1'b1;
        idle(1);

        // Basic decode, then back-to-back packets
        send_pkt(8'h29, 8'h05, 8'hFD, 8'd36, 8'd34, 3'b001, 9'd5,   9'h1FD);
        send_pkt(8'h08, 8'h0A, 8'h08, 8'd46, 8'd26, 3'b000, 9'd10,  9'd8);
        // X clamp high / low, X overflow
        send_pkt(8'h08, 8'h7F, 8'h00, 8'd63, 8'd26, 3'b000, 9'd127, 9'd0);
        send_pkt(8'h18, 8'h80, 8'h00, 8'd0,  8'd26, 3'b000, 9'h180, 9'd0);
        send_pkt(8'h48, 8'h20, 8'h00, 8'd0,  8'd26, 3'b000, 9'd0,   9'd0);
        // Y clamp low / high, Y overflow, all buttons
        send_pkt(8'h08, 8'h00, 8'h7F, 8'd0,  8'd0,  3'b000, 9'd0,   9'd127);
        send_pkt(8'h28, 8'h00, 8'h80, 8'd0,  8'd63, 3'b000, 9'd0,   9'h180);
        send_pkt(8'h88, 8'h00, 8'h10, 8'd0,  8'd63, 3'b000, 9'd0,   9'd0);
        send_pkt(8'h0F, 8'h00, 8'h00, 8'd0,  8'd63, 3'b111, 9'd0,   9'd0);
        idle(2);

        // Missing sync bit discards the byte only
        sync_pending++;
        send_byte(8'h05);
        send_pkt(8'h08, 8'h01, 8'h00, 8'd1,  8'd63, 3'b000, 9'd1,   9'd0);
        idle(2);

        // Disabled: bytes ignored, no strobes
        enable = 1'b0;
        send_byte(8'hFA);
        send_byte(8'hAA);
        send_byte(8'h00);
        idle(2);
        check("disabled_cursor_x", 32'(cursor_x), 32'd1);
        enable = 1'b1;
        idle(1);

        // Disable mid-packet abandons it silently
        send_byte(8'h08);
        send_byte(8'h02);
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
        send_pkt(8'h08, 8'h01, 8'h00, 8'd2,  8'd63, 3'b000, 9'd1,   9'd0);
        idle(2);

        // Inter-byte timeout fires on the 40500th idle cycle
        sync_pending++;
        send_byte(8'h08);
        send_byte(8'h05);
        idle(40500);
        send_pkt(8'h08, 8'h02, 8'h00, 8'd4,  8'd63, 3'b000, 9'd2,   9'd0);
        idle(2);

        // Byte arriving on the terminal-count cycle wins over the timeout
        begin
            exp_t e;
            e.x = 8'd11; e.y = 8'd63; e.b = 3'b000; e.dx = 9'd7; e.dy = 9'd0;
            exp_q.push_back(e);
        end
        send_byte(8'h08);
        idle(40499);
        send_byte(8'h07);
        send_byte(8'h00);
        idle(2);

        // Receiver error after byte 1
        sync_pending++;
        send_byte(8'h08);
        send_err();
        send_pkt(8'h08, 8'h03, 8'h00, 8'd14, 8'd63, 3'b000, 9'd3,   9'd0);
        idle(2);

        // rx_err beats a simultaneous rx_valid
        sync_pending++;
        send_byte(8'h08);
        rx_data  = 8'h05;
        rx_valid = 1'b1;
        rx_err   = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        send_pkt(8'h0B, 8'h04, 8'h00, 8'd18, 8'd63, 3'b011, 9'd4,   9'd0);
        idle(2);

        // rx_err while waiting for a status byte is ignored
        send_err();
        idle(3);

        // Asynchronous reset mid-packet
        send_byte(8'h08);
        send_byte(8'h04);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_pkt(8'h29, 8'h05, 8'hFD, 8'd36, 8'd34, 3'b001, 9'd5,   9'h1FD);
        idle(5);

        check("pkt_queue_drained",  32'(exp_q.size()), 32'd0);
        check("sync_queue_drained", 32'(sync_pending), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
